// File: rtl/afifo_pkg.sv
// Shared helpers for the asynchronous FIFO pointer blocks.
//   DEPTH(addrsize)      : number of words for a given address width
//   bin2gray(b, width)   : binary -> reflected Gray code, low 'width' bits used
//   gray2bin(g, width)   : reflected Gray -> binary, low 'width' bits used
// Values are carried in MAXW-bit vectors so one function serves every
// pointer width up to MAXW; callers cast the result to their own width.
package afifo_pkg;

    localparam int MAXW = 32;

    function automatic int DEPTH(input int addrsize);
        return 1 << addrsize;
    endfunction

    function automatic logic [MAXW-1:0] width_mask(input int width);
        logic [MAXW-1:0] m;
        m = '0;
        for (int i = 0; i < MAXW; i++) begin
            if (i < width) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [MAXW-1:0] bin2gray(input logic [MAXW-1:0] b, input int width);
        logic [MAXW-1:0] bm;
        bm = b & width_mask(width);
        return (bm >> 1) ^ bm;
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it; bits above
    // 'width' are forced to zero so they do not disturb the result.
    function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g, input int width);
        logic [MAXW-1:0] gm;
        logic [MAXW-1:0] b;
        gm = g & width_mask(width);
        b = '0;
        b[MAXW-1] = gm[MAXW-1];
        for (int i = MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ gm[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter.
//   gray : W-bit Gray-coded pointer (typically a synchronised remote pointer)
//   bin  : W-bit binary equivalent
module gray2bin_conv
    import afifo_pkg::*;
#(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    assign bin = W'(gray2bin(MAXW'(gray), W));

endmodule

// File: rtl/wptr_full_lvl.sv
// Write-domain pointer and status generator for the asynchronous FIFO.
//   wclk, wrst     : write clock, asynchronous active-high reset
//   winc           : write request
//   wq2_rptr       : Gray read pointer already synchronised into wclk
//   wovf_clr       : clears the sticky overflow flag
//   wen            : memory write strobe (winc & ~wfull, combinational)
//   waddr          : binary memory write address
//   wptr           : registered Gray write pointer for the read domain
//   wfull          : registered full flag
//   walmost_full   : registered, level >= AF_LEVEL
//   wlevel         : registered fill level, 0..DEPTH
//   woverflow      : sticky, set by a write attempt while full
// Flags and level are computed from the lagging synchronised read pointer,
// so they can only over-report the fill, never under-report it.
module wptr_full_lvl
    import afifo_pkg::*;
#(
    parameter int ADDRSIZE = 4,
    parameter int AF_LEVEL = 12
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                wovf_clr,
    output logic                wen,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                woverflow
);

    localparam int FIFO_DEPTH = DEPTH(ADDRSIZE);
    localparam logic [ADDRSIZE:0] AF_THR = (ADDRSIZE+1)'(AF_LEVEL);

    if (ADDRSIZE < 2 || AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH) begin : g_cfg_check
        $error("wptr_full_lvl: illegal ADDRSIZE/AF_LEVEL combination");
    end

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbinnext;
    logic [ADDRSIZE:0] wgraynext;
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] lvlnext;
    logic              full_next;

    gray2bin_conv #(.W(ADDRSIZE + 1)) u_rptr_conv (
        .gray (wq2_rptr),
        .bin  (rbin)
    );

    always_comb begin
        wen       = winc & ~wfull;
        wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wen};
        wgraynext = (ADDRSIZE+1)'(bin2gray(MAXW'(wbinnext), ADDRSIZE + 1));
        // Modulo subtraction stays correct across the pointer wrap.
        lvlnext   = wbinnext - rbin;
        // Full in Gray space: top two bits inverted, the rest equal.
        full_next = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
    end

    assign waddr = wbin[ADDRSIZE-1:0];

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbinnext;
            wptr         <= wgraynext;
            wfull        <= full_next;
            walmost_full <= (lvlnext >= AF_THR);
            wlevel       <= lvlnext;
            // A new overflow outranks a clear arriving in the same cycle.
            if (winc & wfull) begin
                woverflow <= 1'b1;
            end else if (wovf_clr) begin
                woverflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wptr_full_lvl.sv
module tb_wptr_full_lvl;

    logic wclk = 1'b0;
    logic wrst;
    always #5 wclk = ~wclk;

    // Instance 0: ADDRSIZE=4, AF_LEVEL=12
    logic       a_winc, a_clr, a_wen, a_full, a_af, a_ovf;
    logic [4:0] a_rq, a_wptr, a_wlevel;
    logic [3:0] a_waddr;
    // Instance 1: ADDRSIZE=2, AF_LEVEL=4
    logic       b_winc, b_clr, b_wen, b_full, b_af, b_ovf;
    logic [2:0] b_rq, b_wptr, b_wlevel;
    logic [1:0] b_waddr;
    // Instance 2: ADDRSIZE=6, AF_LEVEL=1
    logic       c_winc, c_clr, c_wen, c_full, c_af, c_ovf;
    logic [6:0] c_rq, c_wptr, c_wlevel;
    logic [5:0] c_waddr;

    wptr_full_lvl #(.ADDRSIZE(4), .AF_LEVEL(12)) dut_a (
        .wclk(wclk), .wrst(wrst), .winc(a_winc), .wq2_rptr(a_rq), .wovf_clr(a_clr),
        .wen(a_wen), .waddr(a_waddr), .wptr(a_wptr), .wfull(a_full),
        .walmost_full(a_af), .wlevel(a_wlevel), .woverflow(a_ovf));

    wptr_full_lvl #(.ADDRSIZE(2), .AF_LEVEL(4)) dut_b (
        .wclk(wclk), .wrst(wrst), .winc(b_winc), .wq2_rptr(b_rq), .wovf_clr(b_clr),
        .wen(b_wen), .waddr(b_waddr), .wptr(b_wptr), .wfull(b_full),
        .walmost_full(b_af), .wlevel(b_wlevel), .woverflow(b_ovf));

    wptr_full_lvl #(.ADDRSIZE(6), .AF_LEVEL(1)) dut_c (
        .wclk(wclk), .wrst(wrst), .winc(c_winc), .wq2_rptr(c_rq), .wovf_clr(c_clr),
        .wen(c_wen), .waddr(c_waddr), .wptr(c_wptr), .wfull(c_full),
        .walmost_full(c_af), .wlevel(c_wlevel), .woverflow(c_ovf));

    int checks = 0;
    int errors = 0;

    function automatic void cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // Reference model, one slot per instance
    int maw[3] = '{4, 2, 6};
    int maf[3] = '{12, 4, 1};
    int mbin[3] = '{0, 0, 0};
    int mfull[3] = '{0, 0, 0};
    int maff[3] = '{0, 0, 0};
    int mlvl[3] = '{0, 0, 0};
    int movf[3] = '{0, 0, 0};

    function automatic int b2g(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int g2b(input int g);
        int b = 0;
        for (int t = g; t != 0; t = t >> 1) b = b ^ t;
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mbin[i] = 0; mfull[i] = 0; maff[i] = 0; mlvl[i] = 0; movf[i] = 0;
        end
    endtask

    // Advance one instance's model by one clock edge, given the inputs seen before it.
    task automatic model_edge(input int id, input int winc, input int rq, input int clr);
        int md;
        int dp;
        int we;
        int nb;
        md = 1 << (maw[id] + 1);
        dp = 1 << maw[id];
        we = (winc != 0 && mfull[id] == 0) ? 1 : 0;
        nb = (mbin[id] + we) % md;
        if (winc != 0 && mfull[id] != 0) movf[id] = 1;
        else if (clr != 0) movf[id] = 0;
        mbin[id] = nb;
        mlvl[id] = (nb - g2b(rq) + md) % md;
        mfull[id] = (mlvl[id] == dp) ? 1 : 0;
        maff[id] = (mlvl[id] >= maf[id]) ? 1 : 0;
    endtask

    typedef struct {
        int id; int wen; int waddr; int wptr; int wlevel; int full; int af; int ovf;
    } exp_t;
    exp_t sbq[$];

    task automatic push(input int id, input int winc);
        exp_t e;
        e.id = id;
        e.wen = (winc != 0 && mfull[id] == 0) ? 1 : 0;
        e.waddr = mbin[id] % (1 << maw[id]);
        e.wptr = b2g(mbin[id]);
        e.wlevel = mlvl[id];
        e.full = mfull[id];
        e.af = maff[id];
        e.ovf = movf[id];
        sbq.push_back(e);
    endtask

    // Monitor: after every edge, pop pending expectations and compare with the DUT.
    initial begin
        exp_t e;
        int aw, ad, ap, al, af, aa, ao;
        forever begin
            @(posedge wclk);
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                case (e.id)
                    0: begin aw = a_wen; ad = a_waddr; ap = a_wptr; al = a_wlevel; af = a_full; aa = a_af; ao = a_ovf; end
                    1: begin aw = b_wen; ad = b_waddr; ap = b_wptr; al = b_wlevel; af = b_full; aa = b_af; ao = b_ovf; end
                    default: begin aw = c_wen; ad = c_waddr; ap = c_wptr; al = c_wlevel; af = c_full; aa = c_af; ao = c_ovf; end
                endcase
                cmp($sformatf("d%0d_wen", e.id), aw, e.wen);
                cmp($sformatf("d%0d_waddr", e.id), ad, e.waddr);
                cmp($sformatf("d%0d_wptr", e.id), ap, e.wptr);
                cmp($sformatf("d%0d_wlevel", e.id), al, e.wlevel);
                cmp($sformatf("d%0d_wfull", e.id), af, e.full);
                cmp($sformatf("d%0d_walmost_full", e.id), aa, e.af);
                cmp($sformatf("d%0d_woverflow", e.id), ao, e.ovf);
            end
        end
    end

    // One clock of stimulus on instance 0; starts and ends just after a negedge.
    task automatic step_a(input int winc, input int rq, input int clr);
        a_winc = winc[0];
        a_rq = rq[4:0];
        a_clr = clr[0];
        @(posedge wclk);
        model_edge(0, winc, rq, clr);
        push(0, winc);
        @(negedge wclk);
    endtask

    task automatic check_a_zero(input string tag);
        cmp({tag, "_waddr"}, a_waddr, 0);
        cmp({tag, "_wptr"}, a_wptr, 0);
        cmp({tag, "_wfull"}, a_full, 0);
        cmp({tag, "_walmost_full"}, a_af, 0);
        cmp({tag, "_wlevel"}, a_wlevel, 0);
        cmp({tag, "_woverflow"}, a_ovf, 0);
    endtask

    initial begin
        int wb;
        int rb;
        int rb_b;
        int rb_c;
        wrst = 1'b1;
        a_winc = 0; a_clr = 0; a_rq = '0;
        b_winc = 0; b_clr = 0; b_rq = '0;
        c_winc = 0; c_clr = 0; c_rq = '0;
        @(negedge wclk);
        @(negedge wclk);
        check_a_zero("reset");
        wrst = 1'b0;

        // A short burst, then reset asserted between edges
        for (int i = 0; i < 5; i++) step_a(1, 0, 0);
        cmp("burst_waddr", a_waddr, 5);
        #2;
        wrst = 1'b1;
        #1;
        check_a_zero("async_reset");
        cmp("async_reset_wen_follows_winc", a_wen, 1);
        @(posedge wclk);
        #1;
        check_a_zero("reset_held");
        @(negedge wclk);
        a_winc = 0;
        wrst = 1'b0;
        model_reset();

        // Idle after reset
        for (int i = 0; i < 3; i++) step_a(0, 0, 0);
        check_a_zero("idle");

        // Fill from empty
        for (int i = 0; i < 16; i++) begin
            cmp("fill_waddr", a_waddr, i);
            step_a(1, 0, 0);
            if (i == 10) cmp("fill_af_after11", a_af, 0);
            if (i == 11) cmp("fill_af_after12", a_af, 1);
            if (i == 14) cmp("fill_full_after15", a_full, 0);
        end
        cmp("fill_wfull", a_full, 1);
        cmp("fill_wlevel", a_wlevel, 16);
        cmp("fill_wptr", a_wptr, 5'b11000);

        // Overflow while full
        for (int i = 0; i < 3; i++) begin
            step_a(1, 0, 0);
            cmp("ovf_wen", a_wen, 0);
            cmp("ovf_wptr", a_wptr, 5'b11000);
            cmp("ovf_flag", a_ovf, 1);
        end
        step_a(0, 0, 1);
        cmp("ovf_clear", a_ovf, 0);
        step_a(1, 0, 1);
        cmp("ovf_set_beats_clear", a_ovf, 1);
        step_a(0, 0, 0);

        // Drain release
        step_a(0, 5'b00110, 0);
        cmp("drain4_wfull", a_full, 0);
        cmp("drain4_wlevel", a_wlevel, 12);
        cmp("drain4_af", a_af, 1);
        step_a(0, 5'b00111, 0);
        cmp("drain5_af", a_af, 0);
        cmp("drain5_wlevel", a_wlevel, 11);

        // Wrap-around with level kept at 3 or below
        wb = 16;
        rb = 5;
        for (int k = 1; k <= 40; k++) begin
            rb = wb - 2;
            step_a(1, b2g(rb % 32), 0);
            wb++;
            cmp("wrap_wlevel", a_wlevel, 3);
            cmp("wrap_no_full", a_full, 0);
            if (k == 15) cmp("wrap_msb_before16", a_wptr[4], 1);
            if (k == 16) cmp("wrap_msb_after16", a_wptr[4], 0);
            if (k == 31) cmp("wrap_msb_before32", a_wptr[4], 0);
            if (k == 32) cmp("wrap_msb_after32", a_wptr[4], 1);
        end
        a_winc = 0;

        // Parameter sweep on instances 1 and 2
        rb_b = 0;
        rb_c = 0;
        for (int k = 0; k < 400; k++) begin
            int wi_b;
            int wi_c;
            int cl_b;
            int cl_c;
            wi_b = ($urandom_range(0, 9) < 7) ? 1 : 0;
            wi_c = ($urandom_range(0, 9) < 6) ? 1 : 0;
            cl_b = ($urandom_range(0, 9) == 0) ? 1 : 0;
            cl_c = ($urandom_range(0, 9) == 0) ? 1 : 0;
            if ($urandom_range(0, 9) < 3 && rb_b != mbin[1]) rb_b = (rb_b + 1) % 8;
            if ($urandom_range(0, 9) < 4 && rb_c != mbin[2]) rb_c = (rb_c + 1) % 128;
            b_winc = wi_b[0]; b_clr = cl_b[0]; b_rq = 3'(b2g(rb_b));
            c_winc = wi_c[0]; c_clr = cl_c[0]; c_rq = 7'(b2g(rb_c));
            @(posedge wclk);
            model_edge(1, wi_b, b2g(rb_b), cl_b);
            model_edge(2, wi_c, b2g(rb_c), cl_c);
            push(1, wi_b);
            push(2, wi_c);
            @(negedge wclk);
            cmp("d1_full_iff_depth", b_full, (b_wlevel == 3'd4) ? 1 : 0);
            cmp("d1_af_iff_level", b_af, (b_wlevel >= 3'd4) ? 1 : 0);
            cmp("d2_full_iff_depth", c_full, (c_wlevel == 7'd64) ? 1 : 0);
            cmp("d2_af_iff_level", c_af, (c_wlevel >= 7'd1) ? 1 : 0);
        end
        b_winc = 0;
        c_winc = 0;

        @(negedge wclk);
        @(negedge wclk);
        cmp("scoreboard_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
